// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified memory-port arbiter: default widths,
// FSM state encodings and the watchdog counter sizing helper.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_BUS_TIMEOUT = 15;
    localparam int SEL_W           = 4;

    localparam logic [SEL_W-1:0] SEL_WORD = 4'hF;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SRV_MEM = 2'd1;
    localparam state_t ST_SRV_IF  = 2'd2;
    localparam state_t ST_DRAIN   = 2'd3;

    // The bus is owned (and the watchdog running) in every state but IDLE.
    function automatic logic busOwned(input state_t s);
        return s != ST_IDLE;
    endfunction

    function automatic int wdogWidth(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the arbiter, the pipeline requesters and the bus slave.
// slave = arbiter view, master = pipeline/bus environment view.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              flush;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              if_err;
    logic              mem_req;
    logic              mem_we;
    logic [SEL_W-1:0]  mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              mem_err;
    logic              bus_req;
    logic              bus_we;
    logic [SEL_W-1:0]  bus_sel;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              stallreq_if;
    logic              stallreq_mem;

    modport slave (
        input  flush, if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
               bus_rdata, bus_ack,
        output if_rdata, if_ack, if_err, mem_rdata, mem_ack, mem_err,
               bus_req, bus_we, bus_sel, bus_addr, bus_wdata, stallreq_if, stallreq_mem
    );

    modport master (
        output flush, if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
               bus_rdata, bus_ack,
        input  if_rdata, if_ack, if_err, mem_rdata, mem_ack, mem_err,
               bus_req, bus_we, bus_sel, bus_addr, bus_wdata, stallreq_if, stallreq_mem
    );

endinterface

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// Bus watchdog: counts owned-bus cycles and flags the last one allowed
// before the transaction is declared dead. Saturates so the flag stays up.
module mem_port_arbiter_bus_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_BUS_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int              CNT_W = wdogWidth(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_count && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Asserted during the TIMEOUT-th counted cycle, the same slot a late bus_ack would use.
    assign o_expired = i_count && (r_count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory bus between fetch and data access.
// MEM has fixed priority over IF; one transaction in flight; flushed results are dropped.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BUS_TIMEOUT = DEF_BUS_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave arb
);

    state_t            r_state;
    logic              r_busReq;
    logic              r_busWe;
    logic [SEL_W-1:0]  r_busSel;
    logic [ADDR_W-1:0] r_busAddr;
    logic [DATA_W-1:0] r_busWdata;
    logic [DATA_W-1:0] r_ifRdata;
    logic              r_ifAck;
    logic              r_ifErr;
    logic [DATA_W-1:0] r_memRdata;
    logic              r_memAck;
    logic              r_memErr;

    logic w_memGo;
    logic w_ifGo;
    logic w_expired;
    logic w_wdClear;
    logic w_wdCount;

    // A request whose ack is showing this cycle is already served and must not be re-granted.
    assign w_memGo   = arb.mem_req & ~r_memAck;
    assign w_ifGo    = arb.if_req & ~r_ifAck;
    assign w_wdClear = (r_state == ST_IDLE);
    assign w_wdCount = busOwned(r_state) && r_busReq;

    mem_port_arbiter_bus_watchdog #(
        .TIMEOUT (BUS_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_wdClear),
        .i_count   (w_wdCount),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_busReq   <= 1'b0;
            r_busWe    <= 1'b0;
            r_busSel   <= '0;
            r_busAddr  <= '0;
            r_busWdata <= '0;
            r_ifRdata  <= '0;
            r_ifAck    <= 1'b0;
            r_ifErr    <= 1'b0;
            r_memRdata <= '0;
            r_memAck   <= 1'b0;
            r_memErr   <= 1'b0;
        end else begin
            r_ifAck  <= 1'b0;
            r_ifErr  <= 1'b0;
            r_memAck <= 1'b0;
            r_memErr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!arb.flush) begin
                        if (w_memGo) begin
                            r_busWe    <= arb.mem_we;
                            r_busSel   <= arb.mem_sel;
                            r_busAddr  <= arb.mem_addr;
                            r_busWdata <= arb.mem_wdata;
                            r_busReq   <= 1'b1;
                            r_state    <= ST_SRV_MEM;
                        end else if (w_ifGo) begin
                            r_busWe   <= 1'b0;
                            r_busSel  <= SEL_WORD;
                            r_busAddr <= arb.if_addr;
                            r_busReq  <= 1'b1;
                            r_state   <= ST_SRV_IF;
                        end
                    end
                end
                ST_SRV_MEM, ST_SRV_IF: begin
                    // A real ack outranks the watchdog; a flush suppresses whichever result arrives.
                    if (arb.bus_ack || w_expired) begin
                        r_busReq <= 1'b0;
                        r_state  <= ST_IDLE;
                        if (!arb.flush) begin
                            if (r_state == ST_SRV_MEM) begin
                                r_memAck   <= 1'b1;
                                r_memErr   <= ~arb.bus_ack;
                                r_memRdata <= arb.bus_ack ? arb.bus_rdata : '0;
                            end else begin
                                r_ifAck   <= 1'b1;
                                r_ifErr   <= ~arb.bus_ack;
                                r_ifRdata <= arb.bus_ack ? arb.bus_rdata : '0;
                            end
                        end
                    end else if (arb.flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (arb.bus_ack || w_expired) begin
                        r_busReq <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_busReq <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign arb.bus_req      = r_busReq;
    assign arb.bus_we       = r_busWe;
    assign arb.bus_sel      = r_busSel;
    assign arb.bus_addr     = r_busAddr;
    assign arb.bus_wdata    = r_busWdata;
    assign arb.if_rdata     = r_ifRdata;
    assign arb.if_ack       = r_ifAck;
    assign arb.if_err       = r_ifErr;
    assign arb.mem_rdata    = r_memRdata;
    assign arb.mem_ack      = r_memAck;
    assign arb.mem_err      = r_memErr;
    assign arb.stallreq_if  = arb.if_req & ~r_ifAck;
    assign arb.stallreq_mem = arb.mem_req & ~r_memAck;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomised
// back-to-back run, with expected bus requests and responses held in scoreboard queues.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct packed {
        logic        isMem;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } busTxn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    resp_t       expResp[$];
    busTxn_t     expBus[$];
    logic [31:0] slaveData[$];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) arb ();

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .BUS_TIMEOUT (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; samples are taken 1 unit later still.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        arb.flush     = 1'b0;
        arb.if_req    = 1'b0;
        arb.if_addr   = '0;
        arb.mem_req   = 1'b0;
        arb.mem_we    = 1'b0;
        arb.mem_sel   = '0;
        arb.mem_addr  = '0;
        arb.mem_wdata = '0;
        arb.bus_ack   = 1'b0;
        arb.bus_rdata = '0;
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1'b1;
        repeat (2) nextCycle();
        #1;
        tests++;
        if ({arb.bus_req, arb.if_ack, arb.if_err, arb.mem_ack, arb.mem_err} !== 5'b0)
            begin fails++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {arb.bus_req, arb.if_ack, arb.if_err, arb.mem_ack, arb.mem_err}); end
        tests++;
        if ({arb.if_rdata, arb.mem_rdata} !== 64'h0)
            begin fails++; $display("[TB] FAIL reset_rdata: got %h expected 0", {arb.if_rdata, arb.mem_rdata}); end
        tests++;
        if ({arb.bus_we, arb.bus_sel, arb.bus_addr, arb.bus_wdata, arb.stallreq_if, arb.stallreq_mem} !== 71'h0)
            begin fails++; $display("[TB] FAIL reset_busfields: got %h expected 0", {arb.bus_we, arb.bus_sel, arb.bus_addr, arb.bus_wdata}); end
        nextCycle();
        rst = 1'b0;
        nextCycle();
    endtask

    task automatic test_if_read();
        busTxn_t t;
        resp_t   r;
        nextCycle();
        arb.if_req  = 1'b1;
        arb.if_addr = 32'h0000_0100;
        expBus.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h0000_0100, wdata: 32'h0});
        expResp.push_back('{isMem: 1'b0, rdata: 32'h3C00_0001, err: 1'b0});
        #1;
        tests++;
        if ({arb.stallreq_if, arb.bus_req} !== 2'b10)
            begin fails++; $display("[TB] FAIL if_c0: stall/bus_req got %b expected 10", {arb.stallreq_if, arb.bus_req}); end
        nextCycle(); #1;
        t = expBus.pop_front();
        tests++;
        if ({arb.bus_req, arb.bus_we, arb.bus_sel, arb.bus_addr, arb.stallreq_if} !== {1'b1, t.we, t.sel, t.addr, 1'b1})
            begin fails++; $display("[TB] FAIL if_grant_c1: got %h expected %h", {arb.bus_req, arb.bus_we, arb.bus_sel, arb.bus_addr, arb.stallreq_if}, {1'b1, t.we, t.sel, t.addr, 1'b1}); end
        nextCycle();
        arb.bus_ack   = 1'b1;
        arb.bus_rdata = 32'h3C00_0001;
        #1;
        tests++;
        if ({arb.stallreq_if, arb.if_ack} !== 2'b10)
            begin fails++; $display("[TB] FAIL if_c2: stall/ack got %b expected 10", {arb.stallreq_if, arb.if_ack}); end
        nextCycle();
        arb.bus_ack = 1'b0;
        #1;
        r = expResp.pop_front();
        tests++;
        if ({arb.if_ack, arb.if_err, arb.if_rdata, arb.mem_ack} !== {1'b1, r.err, r.rdata, 1'b0})
            begin fails++; $display("[TB] FAIL if_ack_c3: got %h expected %h", {arb.if_ack, arb.if_err, arb.if_rdata, arb.mem_ack}, {1'b1, r.err, r.rdata, 1'b0}); end
        tests++;
        if ({arb.bus_req, arb.stallreq_if} !== 2'b00)
            begin fails++; $display("[TB] FAIL if_release_c3: bus_req/stall got %b expected 00", {arb.bus_req, arb.stallreq_if}); end
        arb.if_req = 1'b0;
        nextCycle(); #1;
        tests++;
        if ({arb.if_ack, arb.bus_req} !== 2'b00)
            begin fails++; $display("[TB] FAIL if_c4: ack/bus_req got %b expected 00", {arb.if_ack, arb.bus_req}); end
    endtask

    task automatic test_priority();
        busTxn_t t;
        resp_t   r;
        nextCycle();
        arb.mem_req   = 1'b1;
        arb.mem_we    = 1'b1;
        arb.mem_sel   = 4'hF;
        arb.mem_addr  = 32'h0000_0010;
        arb.mem_wdata = 32'hDEAD_BEEF;
        arb.if_req    = 1'b1;
        arb.if_addr   = 32'h0000_0200;
        expBus.push_back('{we: 1'b1, sel: 4'hF, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF});
        expBus.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h0000_0200, wdata: 32'h0});
        expResp.push_back('{isMem: 1'b1, rdata: 32'hA5A5_A5A5, err: 1'b0});
        expResp.push_back('{isMem: 1'b0, rdata: 32'h1234_5678, err: 1'b0});
        #1;
        tests++;
        if ({arb.stallreq_mem, arb.stallreq_if} !== 2'b11)
            begin fails++; $display("[TB] FAIL prio_stall_c0: got %b expected 11", {arb.stallreq_mem, arb.stallreq_if}); end
        nextCycle(); #1;
        t = expBus.pop_front();
        tests++;
        if ({arb.bus_req, arb.bus_we, arb.bus_sel, arb.bus_addr, arb.bus_wdata} !== {1'b1, t})
            begin fails++; $display("[TB] FAIL prio_mem_grant: got %h expected %h", {arb.bus_req, arb.bus_we, arb.bus_sel, arb.bus_addr, arb.bus_wdata}, {1'b1, t}); end
        arb.mem_addr  = 32'h0000_0099;
        arb.mem_wdata = 32'h0;
        nextCycle();
        arb.bus_ack   = 1'b1;
        arb.bus_rdata = 32'hA5A5_A5A5;
        #1;
        tests++;
        if ({arb.bus_addr, arb.bus_wdata} !== {t.addr, t.wdata})
            begin fails++; $display("[TB] FAIL prio_latched: got %h expected %h", {arb.bus_addr, arb.bus_wdata}, {t.addr, t.wdata}); end
        nextCycle();
        arb.bus_ack = 1'b0;
        #1;
        r = expResp.pop_front();
        tests++;
        if ({arb.mem_ack, arb.mem_err, arb.mem_rdata, arb.if_ack, arb.bus_req} !== {1'b1, r.err, r.rdata, 1'b0, 1'b0})
            begin fails++; $display("[TB] FAIL prio_mem_ack: got %h expected %h", {arb.mem_ack, arb.mem_err, arb.mem_rdata, arb.if_ack, arb.bus_req}, {1'b1, r.err, r.rdata, 1'b0, 1'b0}); end
        tests++;
        if ({arb.stallreq_mem, arb.stallreq_if} !== 2'b01)
            begin fails++; $display("[TB] FAIL prio_stall_ack: got %b expected 01", {arb.stallreq_mem, arb.stallreq_if}); end
        arb.mem_req = 1'b0;
        nextCycle(); #1;
        t = expBus.pop_front();
        tests++;
        if ({arb.bus_req, arb.bus_we, arb.bus_sel, arb.bus_addr} !== {1'b1, t.we, t.sel, t.addr})
            begin fails++; $display("[TB] FAIL prio_if_grant: got %h expected %h", {arb.bus_req, arb.bus_we, arb.bus_sel, arb.bus_addr}, {1'b1, t.we, t.sel, t.addr}); end
        nextCycle();
        arb.bus_ack   = 1'b1;
        arb.bus_rdata = 32'h1234_5678;
        nextCycle();
        arb.bus_ack = 1'b0;
        #1;
        r = expResp.pop_front();
        tests++;
        if ({arb.if_ack, arb.if_err, arb.if_rdata, arb.mem_ack} !== {1'b1, r.err, r.rdata, 1'b0})
            begin fails++; $display("[TB] FAIL prio_if_ack: got %h expected %h", {arb.if_ack, arb.if_err, arb.if_rdata, arb.mem_ack}, {1'b1, r.err, r.rdata, 1'b0}); end
        arb.if_req = 1'b0;
        nextCycle();
    endtask

    task automatic test_flush_drain();
        int bad = 0;
        nextCycle();
        arb.if_req  = 1'b1;
        arb.if_addr = 32'h0000_0300;
        nextCycle(); #1;
        if (arb.bus_req !== 1'b1) bad++;
        nextCycle();
        arb.flush = 1'b1;
        #1;
        if (arb.bus_req !== 1'b1) bad++;
        nextCycle();
        arb.flush  = 1'b0;
        arb.if_req = 1'b0;
        #1;
        if ({arb.bus_req, arb.if_ack} !== 2'b10) bad++;
        tests++;
        if (bad !== 0)
            begin fails++; $display("[TB] FAIL drain_hold: bad cycles got %0d expected 0", bad); end
        nextCycle();
        arb.bus_ack   = 1'b1;
        arb.bus_rdata = 32'hBAD0_BAD0;
        #1;
        tests++;
        if ({arb.bus_req, arb.if_ack} !== 2'b10)
            begin fails++; $display("[TB] FAIL drain_ack_cycle: bus_req/ack got %b expected 10", {arb.bus_req, arb.if_ack}); end
        nextCycle();
        arb.bus_ack = 1'b0;
        #1;
        tests++;
        if ({arb.bus_req, arb.if_ack, arb.if_err, arb.if_rdata} !== {3'b000, 32'h1234_5678})
            begin fails++; $display("[TB] FAIL drain_discard: got %h expected %h", {arb.bus_req, arb.if_ack, arb.if_err, arb.if_rdata}, {3'b000, 32'h1234_5678}); end
        nextCycle(); #1;
        tests++;
        if ({arb.bus_req, arb.if_ack} !== 2'b00)
            begin fails++; $display("[TB] FAIL drain_idle: got %b expected 00", {arb.bus_req, arb.if_ack}); end
    endtask

    task automatic test_timeout();
        resp_t r;
        int    bad = 0;
        nextCycle();
        arb.mem_req  = 1'b1;
        arb.mem_we   = 1'b0;
        arb.mem_sel  = 4'h3;
        arb.mem_addr = 32'h0000_0040;
        expResp.push_back('{isMem: 1'b1, rdata: 32'h0, err: 1'b1});
        for (int c = 1; c <= 15; c++) begin
            nextCycle(); #1;
            if ({arb.bus_req, arb.mem_ack} !== 2'b10) bad++;
        end
        tests++;
        if (bad !== 0)
            begin fails++; $display("[TB] FAIL timeout_wait: bad cycles got %0d expected 0", bad); end
        nextCycle(); #1;
        r = expResp.pop_front();
        tests++;
        if ({arb.mem_ack, arb.mem_err, arb.mem_rdata, arb.bus_req} !== {1'b1, r.err, r.rdata, 1'b0})
            begin fails++; $display("[TB] FAIL timeout_err: got %h expected %h", {arb.mem_ack, arb.mem_err, arb.mem_rdata, arb.bus_req}, {1'b1, r.err, r.rdata, 1'b0}); end
        arb.mem_req = 1'b0;
        nextCycle(); #1;
        tests++;
        if ({arb.mem_ack, arb.mem_err, arb.bus_req} !== 3'b000)
            begin fails++; $display("[TB] FAIL timeout_pulse: got %b expected 000", {arb.mem_ack, arb.mem_err, arb.bus_req}); end
    endtask

    task automatic test_flush_with_ack();
        nextCycle();
        arb.mem_req  = 1'b1;
        arb.mem_we   = 1'b0;
        arb.mem_addr = 32'h0000_0050;
        nextCycle();
        nextCycle();
        arb.flush     = 1'b1;
        arb.bus_ack   = 1'b1;
        arb.bus_rdata = 32'h0000_0077;
        #1;
        tests++;
        if (arb.bus_req !== 1'b1)
            begin fails++; $display("[TB] FAIL flushack_pre: bus_req got %b expected 1", arb.bus_req); end
        nextCycle();
        arb.flush   = 1'b0;
        arb.bus_ack = 1'b0;
        arb.mem_req = 1'b0;
        #1;
        tests++;
        if ({arb.mem_ack, arb.mem_err, arb.bus_req, arb.mem_rdata} !== {3'b000, 32'h0})
            begin fails++; $display("[TB] FAIL flushack_drop: got %h expected 0", {arb.mem_ack, arb.mem_err, arb.bus_req, arb.mem_rdata}); end
        nextCycle(); #1;
        tests++;
        if ({arb.mem_ack, arb.bus_req} !== 2'b00)
            begin fails++; $display("[TB] FAIL flushack_idle: got %b expected 00", {arb.mem_ack, arb.bus_req}); end
    endtask

    task automatic test_reset_mid();
        nextCycle();
        arb.mem_req   = 1'b1;
        arb.mem_we    = 1'b1;
        arb.mem_sel   = 4'hC;
        arb.mem_addr  = 32'h0000_0060;
        arb.mem_wdata = 32'hCAFE_F00D;
        nextCycle(); #1;
        tests++;
        if ({arb.bus_req, arb.bus_wdata} !== {1'b1, 32'hCAFE_F00D})
            begin fails++; $display("[TB] FAIL rstmid_grant: got %h expected %h", {arb.bus_req, arb.bus_wdata}, {1'b1, 32'hCAFE_F00D}); end
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst         = 1'b0;
        arb.mem_req = 1'b0;
        #1;
        tests++;
        if ({arb.bus_req, arb.if_ack, arb.if_err, arb.mem_ack, arb.mem_err, arb.if_rdata, arb.mem_rdata} !== 69'h0)
            begin fails++; $display("[TB] FAIL rstmid_outputs: got %h expected 0", {arb.bus_req, arb.if_ack, arb.if_err, arb.mem_ack, arb.mem_err, arb.if_rdata, arb.mem_rdata}); end
        tests++;
        if ({arb.bus_we, arb.bus_sel, arb.bus_addr, arb.bus_wdata} !== 69'h0)
            begin fails++; $display("[TB] FAIL rstmid_busfields: got %h expected 0", {arb.bus_we, arb.bus_sel, arb.bus_addr, arb.bus_wdata}); end
        nextCycle(); #1;
        tests++;
        if (arb.bus_req !== 1'b0)
            begin fails++; $display("[TB] FAIL rstmid_idle: bus_req got %b expected 0", arb.bus_req); end
    endtask

    task automatic test_back_to_back();
        busTxn_t     t;
        resp_t       r;
        logic        prevReq;
        logic [31:0] gotData;
        int          mode;
        int          cd;
        for (int round = 0; round < 8; round++) begin
            mode = $urandom_range(0, 2);
            nextCycle();
            if (mode != 1) begin
                arb.mem_req   = 1'b1;
                arb.mem_we    = 1'($urandom_range(0, 1));
                arb.mem_sel   = 4'($urandom_range(1, 15));
                arb.mem_addr  = $urandom;
                arb.mem_wdata = $urandom;
                expBus.push_back('{we: arb.mem_we, sel: arb.mem_sel, addr: arb.mem_addr, wdata: arb.mem_wdata});
                slaveData.push_back($urandom);
                expResp.push_back('{isMem: 1'b1, rdata: slaveData[slaveData.size()-1], err: 1'b0});
            end
            if (mode != 0) begin
                arb.if_req  = 1'b1;
                arb.if_addr = $urandom;
                expBus.push_back('{we: 1'b0, sel: 4'hF, addr: arb.if_addr, wdata: 32'h0});
                slaveData.push_back($urandom);
                expResp.push_back('{isMem: 1'b0, rdata: slaveData[slaveData.size()-1], err: 1'b0});
            end
            prevReq = 1'b0;
            cd      = 0;
            for (int c = 0; c < 40 && expResp.size() > 0; c++) begin
                nextCycle();
                arb.bus_ack = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0 && slaveData.size() > 0) begin
                        arb.bus_ack   = 1'b1;
                        arb.bus_rdata = slaveData.pop_front();
                    end
                end
                #1;
                if (arb.bus_req && !prevReq) begin
                    cd = $urandom_range(1, 3);
                    t  = (expBus.size() > 0) ? expBus.pop_front() : '1;
                    tests++;
                    if ({arb.bus_we, arb.bus_sel, arb.bus_addr} !== {t.we, t.sel, t.addr} || (t.we && arb.bus_wdata !== t.wdata))
                        begin fails++; $display("[TB] FAIL b2b_bus r%0d: got %h expected %h", round, {arb.bus_we, arb.bus_sel, arb.bus_addr, arb.bus_wdata}, t); end
                end
                prevReq = arb.bus_req;
                if (arb.mem_ack || arb.if_ack) begin
                    r       = expResp.pop_front();
                    gotData = arb.mem_ack ? arb.mem_rdata : arb.if_rdata;
                    tests++;
                    if ({arb.mem_ack, arb.if_ack, gotData, arb.mem_err | arb.if_err} !== {r.isMem, ~r.isMem, r.rdata, r.err})
                        begin fails++; $display("[TB] FAIL b2b_resp r%0d: got %h expected %h", round, {arb.mem_ack, arb.if_ack, gotData, arb.mem_err | arb.if_err}, {r.isMem, ~r.isMem, r.rdata, r.err}); end
                    if (arb.mem_ack) arb.mem_req = 1'b0;
                    if (arb.if_ack)  arb.if_req  = 1'b0;
                end
            end
            tests++;
            if (expResp.size() !== 0)
                begin fails++; $display("[TB] FAIL b2b_pending r%0d: outstanding %0d expected 0", round, expResp.size()); end
            expResp.delete();
            expBus.delete();
            slaveData.delete();
            idleInputs();
            nextCycle();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global time limit expired");
    end

    initial begin
        idleInputs();
        test_reset();
        test_if_read();
        test_priority();
        test_flush_drain();
        test_timeout();
        test_flush_with_ack();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
